// File: rtl/chan_decim_pkg.sv
// -----------------------------------------------------------------------------
// chan_decim_pkg
// Shared types and helpers for the channel-interleaved boxcar decimator and
// its shift/round/saturate stage.
//   shift_t    : 4-bit arithmetic right-shift amount
//   acc_width  : accumulator width for a given sample width and count width
//   sat_hi/lo  : symmetric saturation limits for a signed output width
// -----------------------------------------------------------------------------
package chan_decim_pkg;

  typedef logic [3:0] shift_t;

  // Accumulator holds up to 2^cw samples of dw bits without wrapping.
  function automatic int acc_width(input int dw, input int cw);
    return dw + cw;
  endfunction

  // Symmetric limits: the most negative code is never produced, so the
  // output can always be negated without overflow downstream.
  function automatic int sat_hi(input int ow);
    return (1 << (ow - 1)) - 1;
  endfunction

  function automatic int sat_lo(input int ow);
    return -sat_hi(ow);
  endfunction

endpackage : chan_decim_pkg

// File: rtl/chan_decim_if.sv
// -----------------------------------------------------------------------------
// chan_decim_if
// Sample stream into the decimator and decimated word stream out of it.
//   iq_in/iq_strobe/frame_start : time-multiplexed DSP samples, frame_start
//                                 marks the channel-0 sample
//   dout/dout_strobe            : decimated signed word and its valid
//   dout_chan                   : channel of dout
//   dout_frame                  : first emitted word of a decimated frame
// Modports: master drives samples (DSP side), slave is the decimator.
// -----------------------------------------------------------------------------
interface chan_decim_if #(
  parameter int dw  = 16,
  parameter int ow  = 16,
  parameter int chw = 3
);

  logic signed [dw-1:0]  iq_in;
  logic                  iq_strobe;
  logic                  frame_start;
  logic signed [ow-1:0]  dout;
  logic                  dout_strobe;
  logic [chw-1:0]        dout_chan;
  logic                  dout_frame;

  modport master (
    output iq_in, iq_strobe, frame_start,
    input  dout, dout_strobe, dout_chan, dout_frame
  );

  modport slave (
    input  iq_in, iq_strobe, frame_start,
    output dout, dout_strobe, dout_chan, dout_frame
  );

endinterface : chan_decim_if

// File: rtl/decim_shift_sat.sv
// -----------------------------------------------------------------------------
// decim_shift_sat
// Registered arithmetic right shift + optional rounding + symmetric saturation.
// One register stage; an opaque tag travels alongside the data.
// Optional feature: define CHAN_DECIM_ROUND_EN to add 2^(shift-1) before the
// shift (round half up); otherwise the shift truncates toward -inf.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   i_valid/i_data : signed input word (iw bits) and its valid
//   i_shift        : right-shift amount
//   i_tag          : sideband carried with the word
//   o_valid/o_data : registered saturated word (ow bits)
//   o_tag          : registered sideband
//   o_clip         : the word in o_data was clipped (qualified by o_valid)
// -----------------------------------------------------------------------------
module decim_shift_sat
  import chan_decim_pkg::*;
#(
  parameter int iw = 24,
  parameter int ow = 16,
  parameter int tw = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_valid,
  input  logic signed [iw-1:0] i_data,
  input  shift_t               i_shift,
  input  logic [tw-1:0]        i_tag,
  output logic                 o_valid,
  output logic signed [ow-1:0] o_data,
  output logic [tw-1:0]        o_tag,
  output logic                 o_clip
);

  // One guard bit so the rounding bias cannot overflow a full-scale sum.
  localparam logic signed [iw:0] L_SAT_HI = (iw+1)'(sat_hi(ow));
  localparam logic signed [iw:0] L_SAT_LO = (iw+1)'(sat_lo(ow));

  logic signed [iw:0]   w_ext;
  logic signed [iw:0]   w_bias;
  logic signed [iw:0]   w_rnd;
  logic signed [iw:0]   w_shr;
  logic signed [ow-1:0] w_sat;
  logic                 w_clip;

  // NOTE: every signal written here gets a default before any branch, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_ext  = {i_data[iw-1], i_data};
`ifdef CHAN_DECIM_ROUND_EN
    w_bias = (i_shift != '0) ? ((iw+1)'(1) <<< (i_shift - 4'd1)) : '0;
`else
    w_bias = '0;
`endif
    w_rnd  = w_ext + w_bias;
    w_shr  = w_rnd >>> i_shift;
    w_sat  = w_shr[ow-1:0];
    w_clip = 1'b0;
    if (w_shr > L_SAT_HI) begin
      w_sat  = L_SAT_HI[ow-1:0];
      w_clip = 1'b1;
    end else if (w_shr < L_SAT_LO) begin
      w_sat  = L_SAT_LO[ow-1:0];
      w_clip = 1'b1;
    end
  end

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_tag   <= '0;
      o_clip  <= 1'b0;
    end else begin
      o_valid <= i_valid;
      o_clip  <= i_valid & w_clip;
      if (i_valid) begin
        o_data <= w_sat;
        o_tag  <= i_tag;
      end
    end
  end

endmodule : decim_shift_sat

// File: rtl/chan_decim.sv
// -----------------------------------------------------------------------------
// chan_decim
// Channel-interleaved boxcar decimator feeding the circular waveform buffer.
// Each channel is summed over N = max(wave_cnt,1) frames, shifted right by
// wave_shift, saturated symmetrically, and emitted two cycles after the
// channel's last-frame sample. No backpressure: the consumer takes every word.
// Optional feature: CHAN_DECIM_ROUND_EN enables round-half-up before the shift
// (implemented in decim_shift_sat); latency is the same either way.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   io          : chan_decim_if slave (samples in, decimated words out)
//   wave_cnt    : frames per output, 0 behaves as 1 (latched per period)
//   wave_shift  : right shift of the sum (latched per period)
//   chan_mask   : 1 = channel emitted (latched per period)
//   sat_clear   : clears sat_flag (a simultaneous clip wins)
//   sat_flag    : sticky saturation indicator
//   frame_err   : sticky, more than nch strobes between frame_starts
// -----------------------------------------------------------------------------
module chan_decim
  import chan_decim_pkg::*;
#(
  parameter int dw  = 16,
  parameter int ow  = 16,
  parameter int cw  = 8,
  parameter int nch = 8,
  parameter int chw = 3
) (
  input  logic            clk,
  input  logic            rst,
  chan_decim_if.slave     io,
  input  logic [cw-1:0]   wave_cnt,
  input  shift_t          wave_shift,
  input  logic [nch-1:0]  chan_mask,
  input  logic            sat_clear,
  output logic            sat_flag,
  output logic            frame_err
);

  localparam int             aw     = acc_width(dw, cw);
  localparam logic [chw:0]   L_FULL = (chw+1)'(nch);
  localparam logic [chw:0]   L_CNT1 = (chw+1)'(1);
  localparam logic [cw-1:0]  L_ONE  = cw'(1);

  // Frame/channel sequencing state.
  logic              r_synced;
  logic [chw:0]      r_cnt;        // strobes seen in the current frame
  logic [cw-1:0]     r_fcnt;       // frame index within the period
  logic [cw-1:0]     r_n;          // frames per period, latched
  shift_t            r_shift;
  logic [nch-1:0]    r_mask;
  logic              r_emit_seen;  // a word already left this frame
  logic              r_frame_err;
  logic              r_sat_flag;

  logic signed [aw-1:0] r_acc [nch];

  // Pipeline stage 1: full-period sum.
  logic                 r_s1_valid;
  logic signed [aw-1:0] r_s1_sum;
  shift_t               r_s1_shift;
  logic [chw:0]         r_s1_tag;  // {first word of frame, channel}

  logic                 w_fs_hit;
  logic                 w_overrun;
  logic                 w_accept;
  logic [chw-1:0]       w_ch;
  logic [cw-1:0]        w_new_fidx;
  logic [cw-1:0]        w_fidx;
  logic                 w_period_start;
  logic [cw-1:0]        w_n_next;
  logic [cw-1:0]        w_n;
  shift_t               w_shift;
  logic [nch-1:0]       w_mask;
  logic                 w_first;
  logic                 w_last;
  logic                 w_emit;
  logic                 w_first_emit;
  logic signed [aw-1:0] w_iq_ext;
  logic signed [aw-1:0] w_sum;

  logic                 w_s2_valid;
  logic signed [ow-1:0] w_s2_data;
  logic [chw:0]         w_s2_tag;
  logic                 w_s2_clip;

  always_comb begin
    // frame_start only counts when it comes with a sample.
    w_fs_hit  = io.iq_strobe & io.frame_start;
    w_overrun = io.iq_strobe & ~io.frame_start & r_synced & (r_cnt == L_FULL);
    w_accept  = w_fs_hit | (io.iq_strobe & r_synced & (r_cnt != L_FULL));
    w_ch      = w_fs_hit ? '0 : r_cnt[chw-1:0];

    // A new frame wraps to index 0 after the period's last frame; before
    // sync the first frame_start always opens a period.
    w_new_fidx = (!r_synced || (r_fcnt == r_n - L_ONE)) ? '0 : r_fcnt + L_ONE;
    w_fidx     = w_fs_hit ? w_new_fidx : r_fcnt;
    w_period_start = w_fs_hit & (w_new_fidx == '0);

    // Configuration is sampled at the channel-0 strobe of a period and must
    // already apply to that strobe, hence the bypass around the latches.
    w_n_next = (wave_cnt == '0) ? L_ONE : wave_cnt;
    w_n      = w_period_start ? w_n_next   : r_n;
    w_shift  = w_period_start ? wave_shift : r_shift;
    w_mask   = w_period_start ? chan_mask  : r_mask;

    w_first = (w_fidx == '0);
    w_last  = (w_fidx == w_n - L_ONE);
    w_emit  = w_accept & w_last & w_mask[w_ch];
    w_first_emit = w_fs_hit | ~r_emit_seen;

    w_iq_ext = {{cw{io.iq_in[dw-1]}}, io.iq_in};
    // With N==1 the sample is both first and last, so the sum is iq_in alone.
    w_sum    = w_first ? w_iq_ext : r_acc[w_ch] + w_iq_ext;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_synced    <= 1'b0;
      r_cnt       <= '0;
      r_fcnt      <= '0;
      r_n         <= L_ONE;
      r_shift     <= '0;
      r_mask      <= '0;
      r_emit_seen <= 1'b0;
      r_frame_err <= 1'b0;
      r_sat_flag  <= 1'b0;
      r_s1_valid  <= 1'b0;
      r_s1_sum    <= '0;
      r_s1_shift  <= '0;
      r_s1_tag    <= '0;
    end else begin
      if (w_fs_hit) begin
        r_synced <= 1'b1;
        r_cnt    <= L_CNT1;
        r_fcnt   <= w_new_fidx;
        if (w_period_start) begin
          r_n     <= w_n_next;
          r_shift <= wave_shift;
          r_mask  <= chan_mask;
        end
      end else if (w_accept) begin
        r_cnt <= r_cnt + L_CNT1;
      end

      if (w_overrun) r_frame_err <= 1'b1;

      if (w_fs_hit)    r_emit_seen <= w_emit;
      else if (w_emit) r_emit_seen <= 1'b1;

      // Set has priority over clear so a clip is never lost.
      r_sat_flag <= (r_sat_flag & ~sat_clear) | (w_s2_valid & w_s2_clip);

      r_s1_valid <= w_emit;
      if (w_emit) begin
        r_s1_sum   <= w_sum;
        r_s1_shift <= w_shift;
        r_s1_tag   <= {w_first_emit, w_ch};
      end
    end
  end

  // NOTE: the accumulator array is deliberately not reset: the first frame of
  // every period overwrites each entry, and a reset would prevent mapping it
  // onto distributed RAM.
  always_ff @(posedge clk) begin
    if (w_accept) r_acc[w_ch] <= w_sum;
  end

  decim_shift_sat #(
    .iw (aw),
    .ow (ow),
    .tw (chw + 1)
  ) u_shift_sat (
    .clk     (clk),
    .rst     (rst),
    .i_valid (r_s1_valid),
    .i_data  (r_s1_sum),
    .i_shift (r_s1_shift),
    .i_tag   (r_s1_tag),
    .o_valid (w_s2_valid),
    .o_data  (w_s2_data),
    .o_tag   (w_s2_tag),
    .o_clip  (w_s2_clip)
  );

  assign io.dout        = w_s2_data;
  assign io.dout_strobe = w_s2_valid;
  assign io.dout_chan   = w_s2_tag[chw-1:0];
  assign io.dout_frame  = w_s2_tag[chw];
  assign sat_flag       = r_sat_flag;
  assign frame_err      = r_frame_err;

endmodule : chan_decim

// File: tb/tb_chan_decim.sv
// -----------------------------------------------------------------------------
// tb_chan_decim
// Directed bench for chan_decim (nch=8, dw=ow=16, cw=8). Inputs are driven on
// the falling edge; outputs are collected on the falling edge by a monitor and
// compared against hand-computed expected words. CHAN_DECIM_ROUND_EN selects
// the expected rounding results.
// -----------------------------------------------------------------------------
module tb_chan_decim;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] wave_cnt;
  logic [3:0] wave_shift;
  logic [7:0] chan_mask;
  logic       sat_clear;
  logic       sat_flag;
  logic       frame_err;

  chan_decim_if #(.dw(16), .ow(16), .chw(3)) bus ();

  chan_decim #(
    .dw(16), .ow(16), .cw(8), .nch(8), .chw(3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .io         (bus),
    .wave_cnt   (wave_cnt),
    .wave_shift (wave_shift),
    .chan_mask  (chan_mask),
    .sat_clear  (sat_clear),
    .sat_flag   (sat_flag),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  int obs_dout[$], obs_chan[$], obs_frame[$], obs_cyc[$];
  int exp_dout[$], exp_chan[$], exp_frame[$];

  logic signed [15:0] vec [16];
  int drv_cyc0;

  always @(negedge clk) begin
    if (bus.dout_strobe) begin
      obs_dout.push_back(int'(bus.dout));
      obs_chan.push_back(int'(bus.dout_chan));
      obs_frame.push_back(int'(bus.dout_frame));
      obs_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic push_exp(input int d, input int c, input int f);
    exp_dout.push_back(d);
    exp_chan.push_back(c);
    exp_frame.push_back(f);
  endtask

  task automatic check_outs(input string tag);
    check({tag, "_count"}, obs_dout.size(), exp_dout.size());
    for (int i = 0; i < exp_dout.size() && i < obs_dout.size(); i++) begin
      check($sformatf("%s_dout%0d", tag, i),  obs_dout[i],  exp_dout[i]);
      check($sformatf("%s_chan%0d", tag, i),  obs_chan[i],  exp_chan[i]);
      check($sformatf("%s_frame%0d", tag, i), obs_frame[i], exp_frame[i]);
    end
    obs_dout.delete(); obs_chan.delete(); obs_frame.delete(); obs_cyc.delete();
    exp_dout.delete(); exp_chan.delete(); exp_frame.delete();
  endtask

  // Back-to-back strobes, frame_start on the first, one idle cycle after.
  task automatic send_frame(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == 0) drv_cyc0 = cyc;
      bus.iq_in       = vec[i];
      bus.iq_strobe   = 1'b1;
      bus.frame_start = (i == 0);
    end
    @(negedge clk);
    bus.iq_strobe   = 1'b0;
    bus.frame_start = 1'b0;
  endtask

  task automatic stray(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.iq_in       = vec[i];
      bus.iq_strobe   = 1'b1;
      bus.frame_start = 1'b0;
    end
    @(negedge clk);
    bus.iq_strobe = 1'b0;
  endtask

  task automatic drain();
    repeat (6) @(negedge clk);
  endtask

  task automatic fill(input int v);
    for (int i = 0; i < 16; i++) vec[i] = 16'(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int lat_ref;
    bit found;

    rst = 1'b1;
    bus.iq_in = '0; bus.iq_strobe = 1'b0; bus.frame_start = 1'b0;
    wave_cnt = 8'd4; wave_shift = 4'd2; chan_mask = 8'hFF; sat_clear = 1'b0;
    fill(0);
    repeat (3) @(negedge clk);
    check("rst_strobe", int'(bus.dout_strobe), 0);
    check("rst_dout",   int'(bus.dout), 0);
    check("rst_chan",   int'(bus.dout_chan), 0);
    check("rst_frame",  int'(bus.dout_frame), 0);
    check("rst_sat",    int'(sat_flag), 0);
    check("rst_ferr",   int'(frame_err), 0);
    rst = 1'b0;

    // Constant input, N=4, shift 2: (4*1000)>>2 = 1000. Strobes before the
    // first frame_start are ignored; a mid-period wave_cnt change waits.
    fill(7777);
    stray(2);
    fill(1000);
    send_frame(8);
    send_frame(8);
    wave_cnt = 8'd1;
    send_frame(8);
    send_frame(8);
    lat_ref = drv_cyc0;
    for (int c = 0; c < 8; c++) push_exp(1000, c, (c == 0) ? 1 : 0);
    drain();
    check("t1_latency", (obs_cyc.size() > 0) ? obs_cyc[0] - lat_ref : -1, 2);
    check_outs("t1");

    // Positive saturation: 16*32767 >> 0 clips to 32767.
    wave_cnt = 8'd16; wave_shift = 4'd0;
    fill(32767);
    repeat (16) send_frame(8);
    for (int c = 0; c < 8; c++) push_exp(32767, c, (c == 0) ? 1 : 0);
    drain();
    check_outs("t2p");
    check("t2_sat_set", int'(sat_flag), 1);
    @(negedge clk); sat_clear = 1'b1;
    @(negedge clk); sat_clear = 1'b0;
    check("t2_sat_clr", int'(sat_flag), 0);

    // Negative saturation to -32767 with sat_clear held: clips keep it set.
    sat_clear = 1'b1;
    fill(-32768);
    repeat (16) send_frame(8);
    found = 1'b0;
    for (int k = 0; k < 8 && !found; k++) begin
      if (bus.dout_strobe && bus.dout_chan == 3'd7) found = 1'b1;
      else @(negedge clk);
    end
    check("t2_wait_ch7", int'(found), 1);
    check("t2_set_wins", int'(sat_flag), 1);
    @(negedge clk);
    @(negedge clk);
    check("t2_clr_after", int'(sat_flag), 0);
    sat_clear = 1'b0;
    for (int c = 0; c < 8; c++) push_exp(-32767, c, (c == 0) ? 1 : 0);
    drain();
    check_outs("t2n");

    // wave_cnt=0 acts as 1; mask 0x05 keeps channels 0 and 2.
    wave_cnt = 8'd0; wave_shift = 4'd0; chan_mask = 8'h05;
    fill(0);
    vec[0] = 16'(10); vec[1] = 16'(999); vec[2] = 16'(-300);
    send_frame(8);
    vec[0] = 16'(55); vec[2] = 16'(-7);
    send_frame(8);
    push_exp(10, 0, 1); push_exp(-300, 2, 0);
    push_exp(55, 0, 1); push_exp(-7,   2, 0);
    drain();
    check_outs("t3");

    // Ninth strobe is dropped and flagged; N=2, shift 1:
    // (100i + 100i+2) >> 1 = 100i+1.
    wave_cnt = 8'd2; wave_shift = 4'd1; chan_mask = 8'hFF;
    check("t4_ferr_before", int'(frame_err), 0);
    for (int i = 0; i < 8; i++) vec[i] = 16'(100 * i);
    vec[8] = 16'(30000);
    send_frame(9);
    check("t4_ferr_set", int'(frame_err), 1);
    for (int i = 0; i < 8; i++) vec[i] = 16'(100 * i + 2);
    send_frame(8);
    for (int c = 0; c < 8; c++) push_exp(100 * c + 1, c, (c == 0) ? 1 : 0);
    drain();
    check_outs("t4");

    // Reset after 2 of 4 frames; then a fresh period of
    // base+{0,4,8,12}, mean = base+6 with base = 100i-300.
    wave_cnt = 8'd4; wave_shift = 4'd2;
    fill(5000);
    send_frame(8);
    send_frame(8);
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("t5_ferr_cleared", int'(frame_err), 0);
    check("t5_no_strobe", int'(bus.dout_strobe), 0);
    stray(2);
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < 8; i++) vec[i] = 16'(100 * i - 300 + 4 * f);
      send_frame(8);
    end
    for (int c = 0; c < 8; c++) push_exp(100 * c - 294, c, (c == 0) ? 1 : 0);
    drain();
    check_outs("t5");

    // Rounding: sums 6 and -6, shift 2. Mask 0x06 makes ch1 the first word.
    wave_cnt = 8'd2; wave_shift = 4'd2; chan_mask = 8'h06;
    fill(0);
    vec[1] = 16'(3); vec[2] = 16'(-3);
    send_frame(8);
    send_frame(8);
`ifdef CHAN_DECIM_ROUND_EN
    push_exp(2, 1, 1);  push_exp(-1, 2, 0);
`else
    push_exp(1, 1, 1);  push_exp(-2, 2, 0);
`endif
    drain();
    check_outs("t6");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_chan_decim

// File: doc/chan_decim.md
Name: chan_decim

Overview:
- Channel-interleaved boxcar decimator that sits directly upstream of the circular waveform buffer in the LLRF data path.
- Takes the DSP's time-multiplexed sample stream (one channel per strobe, framed by frame_start).
- Sums each channel over wave_cnt frames, scales by wave_shift and saturates.
- Emits one word per enabled channel per decimated frame, with a strobe, for the buffer write port.

Parameters:
- dw, 16, input sample width (signed)
- ow, 16, output word width (signed)
- cw, 8, wave_cnt width; accumulator width is dw+cw
- nch, 8, channels per frame (power of 2, 2..16)
- chw, 3, channel index width, log2(nch)

Ports:
- clk  in  1  single clock (DSP/clk1x domain)
- rst  in  1  synchronous, active-high reset
- iq_in  in  dw  signed sample for current channel
- iq_strobe  in  1  iq_in valid this cycle
- frame_start  in  1  coincides with channel-0 strobe
- wave_cnt  in  cw  frames per decimated output; 0 treated as 1
- wave_shift  in  4  arithmetic right shift applied to the sum
- chan_mask  in  nch  1 = channel emitted
- sat_clear  in  1  clears sat_flag
- dout  out  ow  decimated signed word
- dout_strobe  out  1  dout valid
- dout_chan  out  chw  channel of dout
- dout_frame  out  1  dout is first emitted word of its decimated frame
- sat_flag  out  1  sticky saturation indicator
- frame_err  out  1  sticky: more than nch strobes between frame_starts

Behaviour:
- Reset: all outputs 0; accumulators 0; frame counter 0; synced=0.
- Input is ignored until the first frame_start after reset (synced=1 from then on).
- Channel pointer:
  - frame_start&iq_strobe loads ch=0.
  - Each subsequent strobe increments ch.
  - A strobe after ch=nch-1 without frame_start is dropped and sets frame_err.
  - frame_start without iq_strobe is ignored.
- Frame counter fcnt:
  - Advances on each frame_start.
  - fcnt==0 marks the first frame; fcnt==N-1 marks the last frame.
  - N = max(wave_cnt,1), latched at fcnt==0 of each period; mid-period changes of wave_cnt take effect at the next period.
  - wave_shift and chan_mask are latched the same way.
- Accumulate, per strobe for channel ch:
  - On the first frame: acc[ch] <= sext(iq_in).
  - Otherwise: acc[ch] <= acc[ch] + sext(iq_in), width dw+cw; wrap is impossible for N<=2^cw.
- Emit, on the last-frame strobe of an enabled channel:
  - Pipeline stage 1: sum = acc+iq_in.
  - Stage 2: s = sum >>> shift, saturated to ±(2^(ow-1)-1) (symmetric).
  - dout_strobe pulses exactly 2 cycles after the input strobe, for 1 cycle.
  - When N==1 the sum is iq_in alone.
- Masked channels still accumulate but never strobe.
- dout_frame = 1 on the first enabled channel of each emitted frame.
- Throughput: one output per cycle maximum, no backpressure; the downstream buffer must accept every strobe.
- sat_flag sets on any clip. It is cleared by sat_clear; a set and a clear in the same cycle leave it set.
- Reset mid-period discards partial sums and returns to the unsynced state; no pending strobe is issued.
- Storage: accumulators in a distributed RAM array, nch x (dw+cw).

Optional Feature:
- Macro CHAN_DECIM_ROUND_EN.
- Defined: adds 2^(shift-1) before the shift when shift>0 (round half up); saturation is applied after rounding.
- Undefined: plain truncating arithmetic shift.
- Latency is unchanged either way.

Decomposition:
- Shared package chan_decim_pkg:
  - acc width function (dw+cw)
  - sat limits
  - shift type (4 bits)
- One sub-module, decim_shift_sat: a combinational/registered shift + round + saturate stage, reusable by other DSP taps.
- Accumulator RAM and sequencing stay in chan_decim.

Test Plan:
- Constant input: nch=8, wave_cnt=4, shift=2, iq_in=1000 on all channels, mask=0xFF -> 8 strobes per 4 frames, dout=1000, dout_chan 0..7, dout_frame only on ch0, latency 2 cycles.
- Saturation: iq_in=32767, wave_cnt=16, shift=0 -> dout=32767 and sat_flag=1; iq_in=-32768 -> dout=-32767; sat_clear -> 0.
- Mask/wave_cnt=0: mask=0x05, wave_cnt=0 -> output every frame, channels 0 and 2 only, dout equals input.
- Frame error: 9 strobes between frame_starts -> 9th dropped, frame_err=1, next frame decimates correctly.
- Mid-run reset: rst asserted after 2 of 4 frames -> no output; next full period after a fresh frame_start yields the correct mean.
- Rounding (CHAN_DECIM_ROUND_EN): sum 6, shift=2 -> dout 2 with the macro, 1 without.
